// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed little-endian byte stream, writes words into
// instruction memory, verifies the trailing checksum and then releases the core from reset.
module prog_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    localparam int unsigned CW = ADDR_W + 1;
    localparam logic [31:0] MaxWords = 32'(1) << ADDR_W;

    typedef enum logic [2:0] {
        StHdr,
        StLoad,
        StCsum,
        StRun,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       shift_q, shift_d;
    logic [CW-1:0]     n_q, n_d;
    logic [CW-1:0]     word_cnt_q, word_cnt_d;
    logic [31:0]       sum_q, sum_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;

    logic        accept;
    logic        last_byte;
    logic [31:0] word;

    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            in_ready = (state_q == StHdr) || (state_q == StLoad) || (state_q == StCsum);
        end
    end

    assign accept    = in_valid & in_ready;
    assign last_byte = (byte_cnt_q == 2'd3);
    // First byte of a word ends up in bits [7:0] after four right shifts.
    assign word      = {in_data, shift_q[31:8]};

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        n_d          = n_q;
        word_cnt_d   = word_cnt_q;
        sum_d        = sum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        if (accept) begin
            shift_d    = word;
            byte_cnt_d = byte_cnt_q + 2'd1;
        end

        unique case (state_q)
            StHdr: begin
                if (accept && last_byte) begin
                    if ((word == 32'd0) || (word > MaxWords)) begin
                        state_d = StErr;
                    end else begin
                        n_d        = word[CW-1:0];
                        word_cnt_d = '0;
                        sum_d      = '0;
                        state_d    = StLoad;
                    end
                end
            end
            StLoad: begin
                if (accept && last_byte) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_cnt_q[ADDR_W-1:0];
                    imem_wdata_d = word;
                    sum_d        = sum_q + word;
                    word_cnt_d   = word_cnt_q + CW'(1);
                    if (word_cnt_q == n_q - CW'(1)) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (accept && last_byte) begin
                    state_d = (word == sum_q) ? StRun : StErr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StHdr;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            n_q          <= '0;
            word_cnt_q   <= '0;
            sum_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            n_q          <= n_d;
            word_cnt_q   <= word_cnt_d;
            sum_q        <= sum_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_reset = (state_q != StRun);
    assign done       = (state_q == StRun);
    assign error      = (state_q == StErr);

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader upstream of the `risc_kgp` core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words into the core's instruction memory and verifies a trailing checksum. It holds the core in reset until the program is loaded and verified. On a bad header or checksum mismatch the core is never released.

## Interface
- `ADDR_W`, 10: instruction memory word-address width; capacity is 2^ADDR_W words.
- `clk`  in  1  system clock; every register updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  a byte is offered on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte; a byte transfers when `in_valid & in_ready` at a rising edge.
- `imem_we`  out  1  instruction memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address for the write.
- `imem_wdata`  out  32  word to write.
- `core_reset`  out  1  reset to `risc_kgp`; 1 until load succeeds.
- `done`  out  1  program loaded and checksum matched.
- `error`  out  1  load rejected; sticky until `reset`.

## Operation
- Stream format:
  - 4-byte header giving word count N, little-endian.
  - 4·N program bytes, each word little-endian (first byte lands in bits [7:0]).
  - 4-byte checksum word: the sum of all N program words mod 2^32.
- States:
  - HDR: collect 4 header bytes. On the 4th byte:
    - N==0 or N>2^ADDR_W: go to ERR.
    - Otherwise: latch N, clear the word counter and running sum, go to LOAD.
  - LOAD: collect bytes into a word shift register, with a 2-bit byte counter.
    - On the 4th byte of a word: register `imem_wdata` = assembled word and `imem_addr` = word counter. Pulse `imem_we` the next cycle. Add the word into the running sum. Increment the word counter.
    - After word N-1 is accepted, go to CSUM.
  - CSUM: collect 4 bytes.
    - On the 4th byte, if it equals the running sum, go to RUN. Otherwise go to ERR.
  - RUN: `in_ready`=0, `core_reset`=0, `done`=1. Terminal state.
  - ERR: `in_ready`=0, `core_reset`=1, `error`=1. Terminal state.
- `in_ready`=1 in HDR, LOAD and CSUM, and is forced 0 while `reset` is high.
  - Bytes offered with `in_ready`=0 are ignored and not consumed.
- `in_valid` gaps of any length are allowed mid-word. Partial word state is held.
- The running sum is 32-bit, with carry out discarded.
- The word counter is ADDR_W+1 bits wide, so N = 2^ADDR_W is representable. `imem_addr` is its low ADDR_W bits.

## Timing
- Reset values:
  - state = HDR.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `core_reset`=1, `done`=0, `error`=0.
  - Byte counter, word counter and sum all 0.
- Write latency: if the final byte of a word is accepted at edge t, `imem_we`=1 for exactly the cycle after edge t. `imem_addr` and `imem_wdata` are valid in that same cycle.
- Back-to-back words are possible, at most one write per 4 accepted bytes.
- Release: if the final checksum byte is accepted at edge t, then from edge t+1 onward `done`=1 and `core_reset`=0.
  - The last `imem_we` pulse always precedes this edge by at least 3 cycles, so memory is complete before the core runs.
- Error flagging: `error` rises at the edge after the offending header or checksum byte. `core_reset` stays 1 throughout.
- Reset asserted mid-load: all registers asynchronously return to their reset values and `core_reset` is 1 immediately.
  - Words already written stay in memory. The next stream starts a fresh header.
- Continuous `in_valid` in LOAD: one byte per cycle with no stalls.

## Test plan
- Nominal load: bytes 02 00 00 00, 44 33 22 11, DD CC BB AA, 21 00 DE BB sent back-to-back.
  - Expect `imem_we` pulses with addr 0 / data 0x11223344 and addr 1 / data 0xAABBCCDD.
  - Expect `done`=1 and `core_reset`=0 one cycle after the last byte.
- Checksum mismatch: same stream with final byte 0xBC.
  - Expect 2 writes, then `error`=1, `core_reset` stuck at 1, `in_ready`=0, and any further bytes ignored.
- Bad header: header 00 00 00 00, and separately header 01 04 00 00 (N=1025 with ADDR_W=10).
  - Expect `error`=1 one cycle after the 4th byte and no `imem_we`.
- Throttled stream: nominal stream with `in_valid` toggled randomly (about 50%).
  - Expect identical writes and release.
  - Expect no `imem_we` while a word is only partially received.
- Reset mid-load: assert `reset` after 6 bytes of the nominal stream, then resend the full nominal stream.
  - Expect outputs at reset values during reset and `core_reset`=1 immediately.
  - Expect the second stream to load correctly and release.
- Capacity edge: N=1024 words of incrementing data with the correct sum.
  - Expect the last write at addr 0x3FF, no address wrap to 0, and `done`=1.
